test_runner: RTL
================

// Module: test_runner
//
// PURPOSE
//   Initiator side of the self-test fixture run/running/passed handshake.
//   - After a start-up delay, requests a test run from a fixture (e.g. alu_test).
//   - Supervises the run and enforces a timeout.
//   - Latches the verdict and shows it on the Fomu RGB LED.
//   Sits in the board top level between the clock/reset and any fixture exposing
//   i_run / o_running / o_passed.
//
// PARAMETERS
//   STARTUP  3     idle cycles after reset release before the run is requested
//   TIMEOUT  1000  max cycles from run request to completion (>=2)
//   BLINK_W  4     blink divider width; LED blink period = 2**BLINK_W cycles
//
// PORTS
//   i_clk      in   1  system clock
//   i_rst_n    in   1  asynchronous reset, active low
//   o_run      out  1  run request to fixture (fixture i_run)
//   i_running  in   1  fixture busy (fixture o_running)
//   i_passed   in   1  fixture verdict, valid when i_running falls (fixture o_passed)
//   i_restart  in   1  1-cycle pulse in DONE: re-run the test
//   o_done     out  1  verdict latched
//   o_pass     out  1  test passed (valid when o_done)
//   o_timeout  out  1  run aborted by timeout (valid when o_done)
//   o_led      out  3  {r,g,b} status LED drive, active high
//
// BEHAVIOUR
//   - Reset (async, i_rst_n=0):
//     - state=WAIT, startup count=STARTUP, timeout count=0, blink count=0.
//     - All outputs 0; o_run drops immediately, including mid-run.
//   - All outputs registered; no combinational path from inputs to outputs.
//   - WAIT:
//     - Count decrements each edge.
//     - On the edge where count==0 -> START, o_run<=1.
//     - o_run first high after edge STARTUP+1 (edge 1 = first edge after release).
//   - START:
//     - o_run=1. i_running==1 -> RUN.
//   - RUN:
//     - o_run=1. i_running==0 -> DONE.
//     - Same edge: o_pass<=i_passed, o_done<=1, o_run<=0, o_timeout<=0.
//   - Timeout counter:
//     - Cleared on entry to START; increments each edge in START/RUN.
//     - Width $clog2(TIMEOUT+1); never wraps.
//     - Edge with count==TIMEOUT-1 and no completion -> DONE, o_timeout<=1,
//       o_pass<=0, o_run<=0.
//     - Completion and timeout on the same edge: completion wins.
//   - DONE:
//     - Outputs hold until reset or i_restart.
//     - i_restart=1 -> WAIT, reload STARTUP; o_done, o_pass, o_timeout <= 0.
//     - i_restart ignored in other states.
//   - o_led:
//     - WAIT/START/RUN: 3'b001 (blue).
//     - DONE pass: 3'b010 (green steady).
//     - DONE fail: {blink_msb,0,0} (red blinking).
//     - DONE timeout: {blink_msb,0,blink_msb} (magenta blinking).
//     - Blink counter free-runs from reset.
//   - Fixture may hold i_running for 1 cycle minimum; an i_running pulse seen
//     only while in WAIT or DONE is ignored.
//
// TESTING
//   1. Reset release, fixture raises running 2 cycles after o_run, drops it
//      10 cycles later with passed=1 -> o_run high from edge 4 to fall edge;
//      o_done=1, o_pass=1, o_led=3'b010.
//   2. Same with passed=0 -> o_done=1, o_pass=0, o_timeout=0;
//      o_led toggles 3'b100/3'b000 every 8 cycles.
//   3. TIMEOUT=20, fixture never raises running -> DONE exactly 20 edges after
//      o_run rose; o_timeout=1, o_pass=0, o_run=0.
//   4. running falls on the same edge as the timeout hit -> completion verdict
//      taken, o_timeout=0.
//   5. i_rst_n pulsed low mid-RUN -> o_run, o_done and o_led are 0 immediately
//      (before next edge); full sequence repeats after release.
//   6. In DONE pulse i_restart -> o_done clears next edge; o_run re-rises
//      STARTUP+1 edges later; second pass verdict latched correctly.

Source files
------------

// File: rtl/test_runner.sv
// Drives a self-test fixture through run/running/passed, bounds the run with a timeout,
// latches the verdict and reports it on the RGB LED (blue busy, green pass, red/magenta blink fail/timeout).
module test_runner #(
  parameter int STARTUP = 3,
  parameter int TIMEOUT = 1000,
  parameter int BLINK_W = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic       o_run,
  input  logic       i_running,
  input  logic       i_passed,
  input  logic       i_restart,
  output logic       o_done,
  output logic       o_pass,
  output logic       o_timeout,
  output logic [2:0] o_led
);

  localparam int SW = (STARTUP > 0) ? $clog2(STARTUP + 1) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] START_LOAD = SW'(STARTUP);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_WAIT, S_START, S_RUN, S_DONE} state_t;

  state_t             state;
  logic [SW-1:0]      start_cnt;
  logic [TW-1:0]      tmo_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic [BLINK_W-1:0] blink_nxt;

  assign blink_nxt = blink_cnt + BLINK_W'(1);

  function automatic logic [2:0] verdict_led(input logic pass, input logic tmo, input logic blink);
    if (pass)
      return 3'b010;
    if (tmo)
      return {blink, 1'b0, blink};
    return {blink, 2'b00};
  endfunction

  // LED is computed from the post-edge blink value so it tracks the counter with no lag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_WAIT;
      start_cnt <= START_LOAD;
      tmo_cnt   <= '0;
      blink_cnt <= '0;
      o_run     <= 1'b0;
      o_done    <= 1'b0;
      o_pass    <= 1'b0;
      o_timeout <= 1'b0;
      o_led     <= 3'b000;
    end else begin
      blink_cnt <= blink_nxt;
      case (state)
        S_WAIT: begin
          o_led <= 3'b001;
          if (start_cnt == '0) begin
            state   <= S_START;
            o_run   <= 1'b1;
            tmo_cnt <= '0;
          end else begin
            start_cnt <= start_cnt - SW'(1);
          end
        end
        S_START, S_RUN: begin
          tmo_cnt <= tmo_cnt + TW'(1);
          o_led   <= 3'b001;
          // Completion is checked first so it beats a timeout on the same edge.
          if (state == S_RUN && !i_running) begin
            state     <= S_DONE;
            o_run     <= 1'b0;
            o_done    <= 1'b1;
            o_pass    <= i_passed;
            o_timeout <= 1'b0;
            o_led     <= verdict_led(i_passed, 1'b0, blink_nxt[BLINK_W-1]);
          end else if (tmo_cnt == TMO_LAST) begin
            state     <= S_DONE;
            o_run     <= 1'b0;
            o_done    <= 1'b1;
            o_pass    <= 1'b0;
            o_timeout <= 1'b1;
            o_led     <= verdict_led(1'b0, 1'b1, blink_nxt[BLINK_W-1]);
          end else if (state == S_START && i_running) begin
            state <= S_RUN;
          end
        end
        S_DONE: begin
          if (i_restart) begin
            state     <= S_WAIT;
            start_cnt <= START_LOAD;
            o_done    <= 1'b0;
            o_pass    <= 1'b0;
            o_timeout <= 1'b0;
            o_led     <= 3'b001;
          end else begin
            o_led <= verdict_led(o_pass, o_timeout, blink_nxt[BLINK_W-1]);
          end
        end
        default: state <= S_WAIT;
      endcase
    end
  end

endmodule
